// File: rtl/decode_fwd_stage_pkg.sv
// Shared cpu constants and types for the decode/forward stage.
// No logic; constants and a small helper only.
// Not applicable (no flow control).
package decode_fwd_stage_pkg;

   // datapath and register-file geometry defaults
   localparam int CPU_XLEN = 32;
   localparam int CPU_NREG = 32;
   localparam int CPU_AW   = $clog2(CPU_NREG);

   // encodings of the write-enable and is-load qualifiers from later stages
   localparam logic WEN_ON  = 1'b1;
   localparam logic LOAD_ON = 1'b1;

   // which source feeds an operand
   typedef enum logic [2:0] {
      SRC_ZERO = 3'd0,
      SRC_E    = 3'd1,
      SRC_M    = 3'd2,
      SRC_W    = 3'd3,
      SRC_RF   = 3'd4
   } fwd_src_e;

   // execute stage may forward only a non-load result that writes rd
   function automatic logic e_fwd_ok(input logic valid, input logic wen, input logic load);
      return valid && (wen == WEN_ON) && (load != LOAD_ON);
   endfunction

endpackage

// File: rtl/decode_fwd_stage_fwd_prio_mux.sv
// Operand select for one read port: x0 -> 0, then E > M > W > register file.
// Purely combinational, zero latency.
// No flow control; caller qualifies the per-stage forward enables.
module fwd_prio_mux
   import decode_fwd_stage_pkg::*;
#(
   parameter int XLEN = CPU_XLEN,
   parameter int AW   = CPU_AW
) (
   input  logic [AW-1:0]   rs_i,
   input  logic            e_fwd_i,
   input  logic [AW-1:0]   e_rd_i,
   input  logic [XLEN-1:0] e_val_i,
   input  logic            m_fwd_i,
   input  logic [AW-1:0]   m_rd_i,
   input  logic [XLEN-1:0] m_val_i,
   input  logic            w_fwd_i,
   input  logic [AW-1:0]   w_rd_i,
   input  logic [XLEN-1:0] w_val_i,
   input  logic [XLEN-1:0] rf_val_i,
   output logic [XLEN-1:0] op_o
);

   fwd_src_e sel;

   // pick the youngest producer of rs; x0 is hard-wired to zero
   always_comb begin
      sel = SRC_RF;
      if (rs_i == '0)
         sel = SRC_ZERO;
      else if (e_fwd_i && (e_rd_i == rs_i))
         sel = SRC_E;
      else if (m_fwd_i && (m_rd_i == rs_i))
         sel = SRC_M;
      else if (w_fwd_i && (w_rd_i == rs_i))
         sel = SRC_W;
   end

   // steer the selected value onto the operand
   always_comb begin
      op_o = '0;
      case (sel)
         SRC_E:   op_o = e_val_i;
         SRC_M:   op_o = m_val_i;
         SRC_W:   op_o = w_val_i;
         SRC_RF:  op_o = rf_val_i;
         default: op_o = '0;
      endcase
   end

endmodule

// File: rtl/decode_fwd_stage.sv
// Decode stage: register file, operand forwarding, load-use interlock, X register.
// Latency 1 cycle from an accepted decode instruction to X_valid_o.
// Holds X while x_ready_i is low; d_ready_o drops on load-use hazard, flush, reset or full X.
module decode_fwd_stage
   import decode_fwd_stage_pkg::*;
#(
   parameter int XLEN = CPU_XLEN,
   parameter int NREG = CPU_NREG,
   parameter int NRD  = 2,
   localparam int AW  = $clog2(NREG)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                D_valid_i,
   input  logic [NRD*AW-1:0]   D_rs_i,
   input  logic [NRD-1:0]      D_rs_used_i,
   input  logic [AW-1:0]       D_rd_i,
   output logic                d_ready_o,
   input  logic                E_valid_i,
   input  logic                E_wen_i,
   input  logic                E_load_i,
   input  logic [AW-1:0]       E_rd_i,
   input  logic [XLEN-1:0]     e_val_i,
   input  logic                M_valid_i,
   input  logic                M_wen_i,
   input  logic [AW-1:0]       M_rd_i,
   input  logic [XLEN-1:0]     m_val_i,
   input  logic                W_valid_i,
   input  logic                W_wen_i,
   input  logic [AW-1:0]       W_rd_i,
   input  logic [XLEN-1:0]     W_val_i,
   input  logic                flush_i,
   input  logic                x_ready_i,
   output logic                X_valid_o,
   output logic [AW-1:0]       X_rd_o,
   output logic [NRD*XLEN-1:0] X_val_o,
   output logic [15:0]         stall_cnt_o
);

   logic [XLEN-1:0]     rf_q [NREG];
   logic                x_valid_q, x_valid_d;
   logic [AW-1:0]       x_rd_q, x_rd_d;
   logic [NRD*XLEN-1:0] x_val_q, x_val_d;
   logic [15:0]         stall_cnt_q, stall_cnt_d;

   logic                e_fwd, m_fwd, w_fwd, w_write;
   logic                hazard;
   logic                x_free;
   logic [NRD*XLEN-1:0] op_w;

   assign e_fwd   = e_fwd_ok(E_valid_i, E_wen_i, E_load_i);
   assign m_fwd   = M_valid_i && (M_wen_i == WEN_ON);
   assign w_fwd   = W_valid_i && (W_wen_i == WEN_ON);
   assign w_write = w_fwd && (W_rd_i != '0);

   // register file: synchronous clear, write-back port, x0 never written
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++)
            rf_q[i] <= '0;
      end else if (w_write) begin
         rf_q[W_rd_i] <= W_val_i;
      end
   end

   // one forwarding mux per read port
   for (genvar p = 0; p < NRD; p++) begin : g_port
      fwd_prio_mux #(
         .XLEN (XLEN),
         .AW   (AW)
      ) u_mux (
         .rs_i     (D_rs_i[p*AW +: AW]),
         .e_fwd_i  (e_fwd),
         .e_rd_i   (E_rd_i),
         .e_val_i  (e_val_i),
         .m_fwd_i  (m_fwd),
         .m_rd_i   (M_rd_i),
         .m_val_i  (m_val_i),
         .w_fwd_i  (w_fwd),
         .w_rd_i   (W_rd_i),
         .w_val_i  (W_val_i),
         .rf_val_i (rf_q[D_rs_i[p*AW +: AW]]),
         .op_o     (op_w[p*XLEN +: XLEN])
      );
   end

   // load-use interlock: a used source waits on a load still in execute
   always_comb begin
      hazard = 1'b0;
      for (int p = 0; p < NRD; p++) begin
         if (D_rs_used_i[p] && (D_rs_i[p*AW +: AW] != '0) &&
             E_valid_i && (E_wen_i == WEN_ON) && (E_load_i == LOAD_ON) &&
             (E_rd_i == D_rs_i[p*AW +: AW]))
            hazard = 1'b1;
      end
   end

   assign x_free    = !x_valid_q || x_ready_i;
   assign d_ready_o = !rst_i && !hazard && !flush_i && x_free;

   // X register next state: flush > hold > accept > bubble > drain
   always_comb begin
      x_valid_d   = x_valid_q;
      x_rd_d      = x_rd_q;
      x_val_d     = x_val_q;
      stall_cnt_d = stall_cnt_q;
      if (flush_i) begin
         x_valid_d = 1'b0;
      end else if (!x_free) begin
         x_valid_d = 1'b1;
      end else if (D_valid_i && !hazard) begin
         x_valid_d = 1'b1;
         x_rd_d    = D_rd_i;
         x_val_d   = op_w;
      end else if (D_valid_i) begin
         x_valid_d = 1'b0;
         if (stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         x_valid_d = 1'b0;
      end
   end

   // X register and stall counter with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_valid_q   <= 1'b0;
         x_rd_q      <= '0;
         x_val_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         x_valid_q   <= x_valid_d;
         x_rd_q      <= x_rd_d;
         x_val_q     <= x_val_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign X_valid_o   = x_valid_q;
   assign X_rd_o      = x_rd_q;
   assign X_val_o     = x_val_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_decode_fwd_stage.sv
// Directed bench for decode_fwd_stage: forwarding priority, interlock, hold, flush, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-computed constants.
module tb_decode_fwd_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        D_valid_i;
   logic [9:0]  D_rs_i;
   logic [1:0]  D_rs_used_i;
   logic [4:0]  D_rd_i;
   logic        d_ready_o;
   logic        E_valid_i, E_wen_i, E_load_i;
   logic [4:0]  E_rd_i;
   logic [31:0] e_val_i;
   logic        M_valid_i, M_wen_i;
   logic [4:0]  M_rd_i;
   logic [31:0] m_val_i;
   logic        W_valid_i, W_wen_i;
   logic [4:0]  W_rd_i;
   logic [31:0] W_val_i;
   logic        flush_i;
   logic        x_ready_i;
   logic        X_valid_o;
   logic [4:0]  X_rd_o;
   logic [63:0] X_val_o;
   logic [15:0] stall_cnt_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_i = ~clk_i;

   decode_fwd_stage dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .D_valid_i   (D_valid_i),
      .D_rs_i      (D_rs_i),
      .D_rs_used_i (D_rs_used_i),
      .D_rd_i      (D_rd_i),
      .d_ready_o   (d_ready_o),
      .E_valid_i   (E_valid_i),
      .E_wen_i     (E_wen_i),
      .E_load_i    (E_load_i),
      .E_rd_i      (E_rd_i),
      .e_val_i     (e_val_i),
      .M_valid_i   (M_valid_i),
      .M_wen_i     (M_wen_i),
      .M_rd_i      (M_rd_i),
      .m_val_i     (m_val_i),
      .W_valid_i   (W_valid_i),
      .W_wen_i     (W_wen_i),
      .W_rd_i      (W_rd_i),
      .W_val_i     (W_val_i),
      .flush_i     (flush_i),
      .x_ready_i   (x_ready_i),
      .X_valid_o   (X_valid_o),
      .X_rd_o      (X_rd_o),
      .X_val_o     (X_val_o),
      .stall_cnt_o (stall_cnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_e(input logic v, input logic wen, input logic ld, input logic [4:0] rd, input logic [31:0] val);
      E_valid_i = v; E_wen_i = wen; E_load_i = ld; E_rd_i = rd; e_val_i = val;
   endtask

   task automatic set_m(input logic v, input logic [4:0] rd, input logic [31:0] val);
      M_valid_i = v; M_wen_i = v; M_rd_i = rd; m_val_i = val;
   endtask

   task automatic set_w(input logic v, input logic [4:0] rd, input logic [31:0] val);
      W_valid_i = v; W_wen_i = v; W_rd_i = rd; W_val_i = val;
   endtask

   // rs1 goes to port 1 (upper slice), rs0 to port 0
   task automatic set_d(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [4:0] rd);
      D_valid_i = v; D_rs_i = {rs1, rs0}; D_rs_used_i = used; D_rd_i = rd;
   endtask

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; x_ready_i = 1'b1;
      set_d(1'b0, 5'd0, 5'd0, 2'b00, 5'd0);
      set_e(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      set_m(1'b0, 5'd0, 32'h0);
      set_w(1'b0, 5'd0, 32'h0);

      // reset state
      step();
      #1 chk("rst_d_ready", d_ready_o, 0);
      step();
      chk("rst_x_valid", X_valid_o, 0);
      chk("rst_x_rd", X_rd_o, 0);
      chk("rst_x_val", X_val_o, 0);
      chk("rst_stall", stall_cnt_o, 0);
      rst_i = 1'b0;

      // write-back bypass: W writes x5 while D reads x5
      set_w(1'b1, 5'd5, 32'h1234);
      set_d(1'b1, 5'd5, 5'd0, 2'b01, 5'd9);
      #1 chk("wb_d_ready", d_ready_o, 1);
      step();
      chk("wb_x_valid", X_valid_o, 1);
      chk("wb_x_rd", X_rd_o, 9);
      chk("wb_port0", X_val_o[31:0], 32'h1234);

      // register file now holds x5 on both ports
      set_w(1'b0, 5'd0, 32'h0);
      set_d(1'b1, 5'd5, 5'd5, 2'b11, 5'd10);
      step();
      chk("rf_x5_both", X_val_o, 64'h0000_1234_0000_1234);

      // E beats M beats W for the same register; W also writes x3=0xC
      set_e(1'b1, 1'b1, 1'b0, 5'd3, 32'hA);
      set_m(1'b1, 5'd3, 32'hB);
      set_w(1'b1, 5'd3, 32'hC);
      set_d(1'b1, 5'd3, 5'd0, 2'b01, 5'd1);
      step();
      chk("prio_e", X_val_o[31:0], 32'hA);
      set_e(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      step();
      chk("prio_m", X_val_o[31:0], 32'hB);
      set_m(1'b0, 5'd0, 32'h0);
      set_w(1'b0, 5'd0, 32'h0);
      // E valid but not writing must not forward; x3 comes from the file
      set_e(1'b1, 1'b0, 1'b0, 5'd3, 32'hDEAD);
      step();
      chk("e_nowen_rf", X_val_o[31:0], 32'hC);

      // load-use hazard on port 1
      set_e(1'b1, 1'b1, 1'b1, 5'd7, 32'h7777);
      set_d(1'b1, 5'd0, 5'd7, 2'b11, 5'd2);
      #1 chk("lu_d_ready", d_ready_o, 0);
      step();
      chk("lu_bubble", X_valid_o, 0);
      chk("lu_stall", stall_cnt_o, 1);
      // same source unused -> no interlock
      set_d(1'b1, 5'd0, 5'd7, 2'b01, 5'd2);
      #1 chk("lu_unused_ready", d_ready_o, 1);
      step();
      chk("lu_unused_valid", X_valid_o, 1);
      chk("lu_unused_stall", stall_cnt_o, 1);
      // a load to x0 never interlocks
      set_e(1'b1, 1'b1, 1'b1, 5'd0, 32'h0);
      set_d(1'b1, 5'd0, 5'd0, 2'b11, 5'd2);
      #1 chk("lu_x0_ready", d_ready_o, 1);
      set_e(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

      // hold: load instruction rd=4 reading x5, then stall X for 3 cycles
      set_d(1'b1, 5'd5, 5'd0, 2'b01, 5'd4);
      step();
      chk("hold_load_rd", X_rd_o, 4);
      x_ready_i = 1'b0;
      set_d(1'b1, 5'd3, 5'd0, 2'b01, 5'd6);
      for (int i = 0; i < 3; i++) begin
         #1 chk("hold_d_ready", d_ready_o, 0);
         step();
         chk("hold_valid", X_valid_o, 1);
         chk("hold_rd", X_rd_o, 4);
         chk("hold_val", X_val_o[31:0], 32'h1234);
      end
      x_ready_i = 1'b1;
      #1 chk("release_d_ready", d_ready_o, 1);
      step();
      chk("release_rd", X_rd_o, 6);
      chk("release_val", X_val_o[31:0], 32'hC);

      // flush with valid D, full X, stalled X and a pending load-use hazard
      x_ready_i = 1'b0;
      flush_i = 1'b1;
      set_e(1'b1, 1'b1, 1'b1, 5'd7, 32'h0);
      set_d(1'b1, 5'd7, 5'd0, 2'b01, 5'd8);
      #1 chk("flush_d_ready", d_ready_o, 0);
      step();
      chk("flush_valid", X_valid_o, 0);
      chk("flush_stall", stall_cnt_o, 1);
      flush_i = 1'b0;
      x_ready_i = 1'b1;
      set_e(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

      // x0 stays zero even when written
      set_w(1'b1, 5'd0, 32'hFFFF_FFFF);
      set_d(1'b1, 5'd0, 5'd0, 2'b11, 5'd11);
      step();
      chk("x0_bypass", X_val_o, 64'h0);
      set_w(1'b0, 5'd0, 32'h0);
      step();
      chk("x0_rf", X_val_o, 64'h0);

      // reset mid-stream, with a write-back in flight that cycle
      rst_i = 1'b1;
      set_w(1'b1, 5'd8, 32'h55);
      set_d(1'b1, 5'd5, 5'd8, 2'b11, 5'd12);
      #1 chk("rst2_d_ready", d_ready_o, 0);
      step();
      chk("rst2_valid", X_valid_o, 0);
      chk("rst2_rd", X_rd_o, 0);
      chk("rst2_val", X_val_o, 64'h0);
      chk("rst2_stall", stall_cnt_o, 0);
      rst_i = 1'b0;
      set_w(1'b0, 5'd0, 32'h0);
      step();
      chk("post_rst_valid", X_valid_o, 1);
      chk("post_rst_regs", X_val_o, 64'h0);

      // drain: no decode instruction -> X empties
      set_d(1'b0, 5'd0, 5'd0, 2'b00, 5'd0);
      step();
      chk("drain_valid", X_valid_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/decode_fwd_stage.md
DECODE_FWD_STAGE -- requirements
Module: decode_fwd_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width in bits.
REQ-002 Parameter NREG, 32, architectural register count; AW = clog2(NREG).
REQ-003 Parameter NRD, 2, number of source read ports.
REQ-004 One clock; reset is synchronous and active-high; ports clk_i and rst_i.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 D_valid_i  in  1  decode holds an instruction.
REQ-008 D_rs_i  in  NRD*AW  source register indices, port p at slice p.
REQ-009 D_rs_used_i  in  NRD  port p source is read by the instruction.
REQ-010 D_rd_i  in  AW  destination of the decoded instruction, carried to X.
REQ-011 d_ready_o  out  1  decode instruction accepted this cycle.
REQ-012 E_valid_i, E_wen_i, E_load_i  in  1 each  execute-stage valid / writes rd / is load.
REQ-013 E_rd_i  in  AW; e_val_i  in  XLEN  execute result.
REQ-014 M_valid_i, M_wen_i  in  1 each; M_rd_i  in  AW; m_val_i  in  XLEN  resolved memory-stage result (load data already selected).
REQ-015 W_valid_i, W_wen_i  in  1 each; W_rd_i  in  AW; W_val_i  in  XLEN  write-back data.
REQ-016 flush_i  in  1  kill instruction in D and X.
REQ-017 x_ready_i  in  1  execute accepts the X register.
REQ-018 X_valid_o  out  1; X_rd_o  out  AW; X_val_o  out  NRD*XLEN  registered operands.
REQ-019 stall_cnt_o  out  16  saturating count of load-use bubble cycles.

Function
REQ-020 Register file NREG x XLEN; write at clk edge when W_valid_i & W_wen_i & W_rd_i != 0; index 0 always reads 0.
REQ-021 Per port operand, combinational: rs==0 -> 0; else first match of E (valid, wen, !load), M (valid, wen), W (valid, wen) on rd==rs; else register-file value.
REQ-022 W match forwards W_val_i in the same cycle the write occurs (write-then-read bypass).
REQ-023 hazard = any port p with D_rs_used_i[p], rs!=0, E_valid_i & E_wen_i & E_load_i & E_rd_i==rs.
REQ-024 d_ready_o = !hazard & !flush_i & (!X_valid_o | x_ready_i).
REQ-025 Accept (D_valid_i & d_ready_o): next edge X_valid_o=1, X_val_o = forwarded operands, X_rd_o = D_rd_i; latency 1 cycle.
REQ-026 X_valid_o & !x_ready_i: X register holds all fields unchanged.
REQ-027 D_valid_i & hazard & (!X_valid_o | x_ready_i): next edge X_valid_o=0 (bubble), stall_cnt_o += 1, saturating at 0xFFFF.
REQ-028 No D_valid_i and X drained: X_valid_o goes 0.
REQ-029 flush_i: next edge X_valid_o=0; overrides accept, hold and bubble; no stall count.
REQ-030 Unused ports (D_rs_used_i[p]=0) never raise hazard; their X_val_o slice is don't-care.

Reset
REQ-031 rst_i at a clk edge: X_valid_o=0, X_rd_o=0, X_val_o=0, stall_cnt_o=0, all registers 0; overrides every other event, including an in-flight write-back that cycle.
REQ-032 During reset cycle d_ready_o is 0.

Structure
REQ-033 XLEN default, register-index width and load/write-enable opcode constants live in the shared cpu package.
REQ-034 One sub-module fwd_prio_mux (E>M>W>regfile select for one port), instantiated NRD times via generate.

Verification
REQ-035 W writes x5=0x1234 and D reads rs1=x5 same cycle -> X_val_o port0 = 0x1234 next cycle.
REQ-036 E (non-load) rd=x3 val 0xA, M rd=x3 val 0xB, D reads x3 -> operand 0xA.
REQ-037 E load rd=x7, D reads rs2=x7 used -> d_ready_o=0, X_valid_o=0 next cycle, stall_cnt_o=1; with rs2 unused -> accepted.
REQ-038 X_valid_o=1, x_ready_i=0 for 3 cycles with new D -> X fields unchanged, d_ready_o=0; release -> new instruction loaded 1 cycle later.
REQ-039 flush_i with D_valid_i=1 and X_valid_o=1 -> X_valid_o=0 next cycle, stall_cnt_o unchanged.
REQ-040 Write x0=0xFFFF_FFFF, read x0 -> 0; rst_i mid-stream -> all outputs 0 next cycle, later read of prior-written reg returns 0.
